fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] are zero.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: instruction word driven while oValid=0.
REQ-003 SHALL have ports: iClk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: nRst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: iStall  in  1  hold IF/ID outputs; driven by hazard-unit oStall_IF.
REQ-006 SHALL have ports: iFlush  in  1  redirect fetch and kill IF/ID contents; driven by hazard-unit oFlush_IF.
REQ-007 SHALL have ports: iBrTarget  in  32  redirect address, sampled only when iFlush=1.
REQ-008 SHALL have ports: oMemReq  out  1  instruction-memory request; oMemAddr  out  32  request address.
REQ-009 SHALL have ports: iMemAck  in  1  one-cycle acknowledge; iMemData  in  32  instruction word, valid in the ack cycle.
REQ-010 SHALL have ports: oStall_IF  out  1  fetch busy; feeds hazard-unit iStall_IF.
REQ-011 SHALL have ports: oPc  out  32  IF/ID PC; oInstr  out  32  IF/ID instruction; oValid  out  1  IF/ID slot holds a real instruction.
REQ-012 SHALL have ports: oPerfFetch  out  32  delivered-instruction count; oPerfWait  out  32  fetch-wait cycle count.

Function
REQ-013 SHALL hold a 32-bit fetch PC (fpc) and run an FSM with states S_REQ, S_HOLD, S_DISCARD.
REQ-014 In S_REQ and S_DISCARD SHALL drive oMemReq=1; oMemAddr SHALL stay stable from request until the ack cycle; only one request SHALL be outstanding.
REQ-015 In S_HOLD SHALL drive oMemReq=0.
REQ-016 SHALL drive oStall_IF = oMemReq & ~iMemAck, combinationally; it SHALL NOT depend on iStall or iFlush (no loop through the hazard unit).
REQ-017 S_REQ, ack, ~iFlush, ~iStall: next edge SHALL set oPc=fpc, oInstr=iMemData, oValid=1, fpc=fpc+4; state SHALL stay S_REQ. This gives one instruction per cycle when iMemAck is held high.
REQ-018 S_REQ, ack, ~iFlush, iStall: SHALL capture {fpc, iMemData} in a hold buffer, leave IF/ID outputs unchanged, set fpc=fpc+4 and go to S_HOLD.
REQ-019 S_HOLD, ~iFlush, ~iStall: SHALL load the hold buffer into oPc/oInstr, set oValid=1 and go to S_REQ.
REQ-020 With no instruction delivered, ~iStall and ~iFlush: SHALL set oValid=0 and oInstr=NOP_INSTR (bubble).
REQ-021 iStall without a delivery SHALL hold oPc/oInstr/oValid unchanged.
REQ-022 iFlush SHALL take priority over iStall and ack. Next edge SHALL set oValid=0, oInstr=NOP_INSTR, fpc={iBrTarget[31:2],2'b00}, and any hold buffer SHALL be dropped.
REQ-023 iFlush in S_REQ without ack SHALL go to S_DISCARD, keeping the old oMemAddr.
REQ-024 In S_DISCARD, the ack SHALL drop the data and return to S_REQ, which then requests the redirected fpc.
REQ-025 iFlush in S_DISCARD SHALL update fpc only.
REQ-026 iFlush coincident with ack in S_REQ SHALL drop the data and stay in S_REQ.
REQ-027 iFlush in S_HOLD SHALL go to S_REQ.
REQ-028 fpc arithmetic SHALL be modulo 2^32; fpc 32'hFFFF_FFFC advances to 32'h0000_0000.

Reset
REQ-029 nRst=0 SHALL asynchronously set fpc=RESET_PC, state=S_REQ, oPc=0, oInstr=NOP_INSTR, oValid=0 and both perf counters to 0.
REQ-030 During reset, oMemReq and oStall_IF SHALL be 0; oMemReq SHALL first assert in the cycle after nRst deasserts.
REQ-031 Reset mid-request SHALL abandon the request; a late ack SHALL NOT be expected by the design.

Configuration
REQ-032 Macro FETCH_PERF_EN SHALL gate the performance counters.
REQ-033 With FETCH_PERF_EN defined: oPerfFetch SHALL increment per REQ-017/REQ-019 delivery; oPerfWait SHALL increment each cycle oStall_IF=1; both SHALL wrap at 2^32.
REQ-034 Without FETCH_PERF_EN: oPerfFetch and oPerfWait SHALL be constant 0 and no counter flops SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-035 Reset release, iMemAck tied 1, iMemData=addr: oPc SHALL be 0,4,8 on consecutive cycles with oValid=1 from the 2nd edge, and oStall_IF SHALL stay 0.
REQ-036 Ack latency 3 cycles: oStall_IF=1 for 3 cycles per fetch, oMemAddr stable, with FETCH_PERF_EN oPerfWait=3 after the first fetch.
REQ-037 iStall=1 during ack at fpc=0x10: S_HOLD, outputs frozen; on iStall release oPc=0x10 with captured instr; next request 0x14.
REQ-038 iFlush with iBrTarget=0x103 while a request to 0x20 is pending: 0x20 data discarded on ack, next oMemAddr=0x100, oValid=0 meanwhile.
REQ-039 iFlush and iStall asserted in the same cycle as ack: flush wins, oValid=0, next request goes to the target.
REQ-040 RESET_PC=0xFFFF_FFFC with ack tied 1: oPc SHALL sequence 0xFFFF_FFFC then 0x0000_0000; nRst pulsed mid-wait SHALL return oMemAddr to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID register.
// A single outstanding request goes to instruction memory. Delivered words
// land in IF/ID, or in a one-entry hold buffer while the pipeline is stalled.
// Optional feature macro: FETCH_PERF_EN enables the delivery and wait
// performance counters. When it is undefined, both counters read as constant 0.
//
// Memory handshake: oMemReq/oMemAddr act as valid/payload. Once raised, they
// stay stable until the cycle in which iMemAck is high. iMemData is only
// meaningful in that ack cycle. An ack counts only while oMemReq=1.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iStall,
  input  logic        iFlush,
  input  logic [31:0] iBrTarget,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [31:0] iMemData,
  output logic        oStall_IF,
  output logic [31:0] oPc,
  output logic [31:0] oInstr,
  output logic        oValid,
  output logic [31:0] oPerfFetch,
  output logic [31:0] oPerfWait,
  output logic [1:0]  oDbgState
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic [31:0] fpc, fpcNext;
  logic [31:0] discAddr, discAddrNext;
  logic [31:0] holdPc, holdPcNext;
  logic [31:0] holdInstr, holdInstrNext;
  logic [31:0] pcNext, instrNext;
  logic        validNext;
  logic        reqEn;
  logic        memAck;
  logic        deliver;
  logic [31:0] target;

  // Redirect target is always forced to word alignment.
  assign target    = iBrTarget & ~32'h0000_0003;
  assign oMemReq   = reqEn & (state != S_HOLD);
  assign oMemAddr  = (state == S_DISCARD) ? discAddr : fpc;
  assign memAck    = oMemReq & iMemAck;
  // Must not look at iStall/iFlush: the hazard unit closes that loop.
  assign oStall_IF = oMemReq & ~iMemAck;
  assign oDbgState = state;

  // Keeps requests off the bus until the first edge after reset release.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) reqEn <= 1'b0;
    else       reqEn <= 1'b1;
  end

  // State, fetch PC, hold buffer and IF/ID register.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_REQ;
      fpc       <= RESET_PC;
      discAddr  <= 32'h0;
      holdPc    <= 32'h0;
      holdInstr <= 32'h0;
      oPc       <= 32'h0;
      oInstr    <= NOP_INSTR;
      oValid    <= 1'b0;
    end else begin
      state     <= stateNext;
      fpc       <= fpcNext;
      discAddr  <= discAddrNext;
      holdPc    <= holdPcNext;
      holdInstr <= holdInstrNext;
      oPc       <= pcNext;
      oInstr    <= instrNext;
      oValid    <= validNext;
    end
  end

  // Next-state and IF/ID update; flush outranks ack and stall.
  always_comb begin
    stateNext     = state;
    fpcNext       = fpc;
    discAddrNext  = discAddr;
    holdPcNext    = holdPc;
    holdInstrNext = holdInstr;
    pcNext        = oPc;
    instrNext     = oInstr;
    validNext     = oValid;
    deliver       = 1'b0;
    unique case (state)
      S_REQ: begin
        if (iFlush) begin
          fpcNext   = target;
          validNext = 1'b0;
          instrNext = NOP_INSTR;
          // A request still in flight must be drained before redirecting.
          if (oMemReq && !iMemAck) begin
            stateNext    = S_DISCARD;
            discAddrNext = fpc;
          end
        end else if (memAck) begin
          fpcNext = fpc + 32'd4;
          if (iStall) begin
            holdPcNext    = fpc;
            holdInstrNext = iMemData;
            stateNext     = S_HOLD;
          end else begin
            pcNext    = fpc;
            instrNext = iMemData;
            validNext = 1'b1;
            deliver   = 1'b1;
          end
        end else if (!iStall) begin
          validNext = 1'b0;
          instrNext = NOP_INSTR;
        end
      end
      S_HOLD: begin
        if (iFlush) begin
          // The held word is simply abandoned.
          fpcNext   = target;
          validNext = 1'b0;
          instrNext = NOP_INSTR;
          stateNext = S_REQ;
        end else if (!iStall) begin
          pcNext    = holdPc;
          instrNext = holdInstr;
          validNext = 1'b1;
          deliver   = 1'b1;
          stateNext = S_REQ;
        end
      end
      S_DISCARD: begin
        if (iFlush) fpcNext = target;
        if (memAck) stateNext = S_REQ;
        if (!iStall && !iFlush) begin
          validNext = 1'b0;
          instrNext = NOP_INSTR;
        end
      end
      default: stateNext = S_REQ;
    endcase
  end

`ifdef FETCH_PERF_EN
  // Delivered-instruction and wait-cycle counters, wrapping at 2^32.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oPerfFetch <= 32'h0;
      oPerfWait  <= 32'h0;
    end else begin
      if (deliver)   oPerfFetch <= oPerfFetch + 32'd1;
      if (oStall_IF) oPerfWait  <= oPerfWait + 32'd1;
    end
  end
`else
  assign oPerfFetch = 32'h0;
  assign oPerfWait  = 32'h0;
  logic unusedDeliver;
  assign unusedDeliver = deliver;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-programmable
// instruction-memory responder and a second instance at a wrapping RESET_PC.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nRst, iStall, iFlush;
  logic [31:0] iBrTarget;
  logic        iMemAck;
  logic [31:0] iMemData;
  logic        oMemReq, oStall_IF, oValid;
  logic [31:0] oMemAddr, oPc, oInstr, oPerfFetch, oPerfWait;
  logic [1:0]  oDbgState;

  logic        nRst2, ack2;
  logic [31:0] data2;
  logic        oMemReq2, oStall2, oValid2;
  logic [31:0] oMemAddr2, oPc2, oInstr2, oPerfFetch2, oPerfWait2;
  logic [1:0]  oDbgState2;

  logic        tieAck, ackEn, monEn;
  int          latency;
  int          waitCnt;
  int          nVec = 0;
  int          nErr = 0;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // clock / reset block
  always #5 clk = ~clk;

  // memory responder: ack after 'latency' wait cycles, or tied high
  assign iMemData = memFn(oMemAddr);
  assign iMemAck  = tieAck | (ackEn & oMemReq & (waitCnt == latency));
  assign data2    = memFn(oMemAddr2);

  always @(posedge clk or negedge nRst) begin
    if (!nRst)                    waitCnt <= 0;
    else if (oMemReq && !iMemAck) waitCnt <= waitCnt + 1;
    else                          waitCnt <= 0;
  end

  fetch_unit dut (
    .iClk(clk), .nRst(nRst), .iStall(iStall), .iFlush(iFlush),
    .iBrTarget(iBrTarget), .oMemReq(oMemReq), .oMemAddr(oMemAddr),
    .iMemAck(iMemAck), .iMemData(iMemData), .oStall_IF(oStall_IF),
    .oPc(oPc), .oInstr(oInstr), .oValid(oValid),
    .oPerfFetch(oPerfFetch), .oPerfWait(oPerfWait), .oDbgState(oDbgState)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .iClk(clk), .nRst(nRst2), .iStall(1'b0), .iFlush(1'b0),
    .iBrTarget(32'h0), .oMemReq(oMemReq2), .oMemAddr(oMemAddr2),
    .iMemAck(ack2), .iMemData(data2), .oStall_IF(oStall2),
    .oPc(oPc2), .oInstr(oInstr2), .oValid(oValid2),
    .oPerfFetch(oPerfFetch2), .oPerfWait(oPerfWait2), .oDbgState(oDbgState2)
  );

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, memFn(pc)};
  endfunction

  // one clock with the IF/ID monitor: flush -> bubble, stall -> frozen,
  // otherwise a valid slot must match the head of the expected queue
  task automatic step();
    logic        stallB, flushB, validB;
    logic [31:0] pcB, instrB;
    logic [63:0] e;
    stallB = iStall; flushB = iFlush;
    pcB = oPc; instrB = oInstr; validB = oValid;
    @(posedge clk); #1;
    if (monEn && nRst) begin
      nVec++;
      if (flushB) begin
        if (oValid !== 1'b0 || oInstr !== NOP) begin
          nErr++;
          $display("FAIL flush_bubble: valid=%b instr=%h, need valid=0 instr=%h", oValid, oInstr, NOP);
        end
      end else if (stallB) begin
        if ({oPc, oInstr, oValid} !== {pcB, instrB, validB}) begin
          nErr++;
          $display("FAIL stall_freeze: pc=%h instr=%h valid=%b, need pc=%h instr=%h valid=%b",
                   oPc, oInstr, oValid, pcB, instrB, validB);
        end
      end else if (oValid) begin
        if (exp_q.size() == 0) begin
          nErr++;
          $display("FAIL unexpected_delivery: pc=%h instr=%h, need no delivery", oPc, oInstr);
        end else begin
          e = exp_q.pop_front();
          if ({oPc, oInstr} !== e) begin
            nErr++;
            $display("FAIL delivery: pc=%h instr=%h, need pc=%h instr=%h", oPc, oInstr, e[63:32], e[31:0]);
          end
        end
      end else if (oInstr !== NOP) begin
        nErr++;
        $display("FAIL bubble_instr: instr=%h, need %h", oInstr, NOP);
      end
    end
  endtask

  task automatic drain(input int maxCycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxCycles) begin
      step();
      n++;
    end
    nVec++;
    if (exp_q.size() != 0) begin
      nErr++;
      $display("FAIL drain_timeout: %0d pending, need 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic restart(input logic tie, input int lat);
    monEn = 1'b0; iStall = 1'b0; iFlush = 1'b0;
    tieAck = tie; ackEn = ~tie; latency = lat;
    nRst = 1'b0;
    step(); step();
    nRst = 1'b1; monEn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    nRst = 1'b0; monEn = 1'b0; tieAck = 1'b1; ackEn = 1'b0;
    step(); step();
    nVec++;
    if (oMemReq !== 1'b0 || oStall_IF !== 1'b0 || oValid !== 1'b0 || oInstr !== NOP ||
        oPc !== 32'h0 || oMemAddr !== 32'h0) begin
      nErr++;
      $display("FAIL reset_state: req=%b stall=%b valid=%b instr=%h pc=%h addr=%h, need 0 0 0 %h 0 0",
               oMemReq, oStall_IF, oValid, oInstr, oPc, oMemAddr, NOP);
    end
    nVec++;
    if (oPerfFetch !== 32'h0 || oPerfWait !== 32'h0) begin
      nErr++;
      $display("FAIL reset_perf: fetch=%0d wait=%0d, need 0 0", oPerfFetch, oPerfWait);
    end
    nRst = 1'b1; #1;
    nVec++;
    if (oMemReq !== 1'b0) begin
      nErr++;
      $display("FAIL req_after_release: req=%b, need 0", oMemReq);
    end
    monEn = 1'b1;
    step();
    nVec++;
    if (oMemReq !== 1'b1 || oMemAddr !== 32'h0 || oValid !== 1'b0) begin
      nErr++;
      $display("FAIL first_request: req=%b addr=%h valid=%b, need 1 0 0", oMemReq, oMemAddr, oValid);
    end
  endtask

  task automatic test_pipeline();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(32'(i * 4)));
    for (int i = 0; i < 8; i++) begin
      nVec++;
      if (oStall_IF !== 1'b0) begin
        nErr++;
        $display("FAIL pipe_stall_if: stall=%b, need 0", oStall_IF);
      end
      step();
    end
    drain(0);
    nVec++;
    if (oPerfFetch !== (PERF ? 32'd8 : 32'd0) || oPerfWait !== 32'd0) begin
      nErr++;
      $display("FAIL pipe_perf: fetch=%0d wait=%0d, need %0d 0", oPerfFetch, oPerfWait, PERF ? 8 : 0);
    end
  endtask

  task automatic test_latency();
    restart(1'b0, 3);
    exp_q.push_back(ent(32'h0));
    exp_q.push_back(ent(32'h4));
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 4; c++) begin
        nVec++;
        if (oMemAddr !== 32'(f * 4) || oStall_IF !== (c != 3)) begin
          nErr++;
          $display("FAIL latency: fetch %0d cycle %0d addr=%h stall=%b, need addr=%h stall=%b",
                   f, c, oMemAddr, oStall_IF, 32'(f * 4), (c != 3));
        end
        step();
      end
      if (f == 0) begin
        nVec++;
        if (oPerfWait !== (PERF ? 32'd3 : 32'd0) || oPerfFetch !== (PERF ? 32'd1 : 32'd0)) begin
          nErr++;
          $display("FAIL latency_perf: wait=%0d fetch=%0d, need %0d %0d",
                   oPerfWait, oPerfFetch, PERF ? 3 : 0, PERF ? 1 : 0);
        end
      end
    end
    drain(4);
  endtask

  task automatic test_stall();
    restart(1'b1, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'(i * 4)));
    for (int i = 0; i < 4; i++) step();
    iStall = 1'b1;
    step();
    step();
    nVec++;
    if (oMemReq !== 1'b0) begin
      nErr++;
      $display("FAIL hold_no_req: req=%b, need 0", oMemReq);
    end
    exp_q.push_back(ent(32'h10));
    iStall = 1'b0;
    step();
    nVec++;
    if (oMemAddr !== 32'h14 || oMemReq !== 1'b1) begin
      nErr++;
      $display("FAIL after_hold_addr: addr=%h req=%b, need 00000014 1", oMemAddr, oMemReq);
    end
    exp_q.push_back(ent(32'h14));
    drain(4);
  endtask

  task automatic test_flush();
    restart(1'b1, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(32'(i * 4)));
    for (int i = 0; i < 8; i++) step();
    tieAck = 1'b0; ackEn = 1'b0; #1;
    nVec++;
    if (oMemAddr !== 32'h20 || oStall_IF !== 1'b1) begin
      nErr++;
      $display("FAIL pending_req: addr=%h stall=%b, need 00000020 1", oMemAddr, oStall_IF);
    end
    iFlush = 1'b1; iBrTarget = 32'h103;
    step();
    iFlush = 1'b0;
    step(); step();
    nVec++;
    if (oMemAddr !== 32'h20 || oMemReq !== 1'b1) begin
      nErr++;
      $display("FAIL discard_addr: addr=%h req=%b, need 00000020 1", oMemAddr, oMemReq);
    end
    tieAck = 1'b1;
    step();
    nVec++;
    if (oValid !== 1'b0 || oMemAddr !== 32'h100) begin
      nErr++;
      $display("FAIL redirect: valid=%b addr=%h, need 0 00000100", oValid, oMemAddr);
    end
    exp_q.push_back(ent(32'h100));
    exp_q.push_back(ent(32'h104));
    drain(4);
  endtask

  task automatic test_flush_stall_ack();
    restart(1'b1, 0);
    exp_q.push_back(ent(32'h0));
    exp_q.push_back(ent(32'h4));
    step(); step();
    iFlush = 1'b1; iStall = 1'b1; iBrTarget = 32'h200;
    step();
    iFlush = 1'b0; iStall = 1'b0;
    nVec++;
    if (oValid !== 1'b0 || oMemAddr !== 32'h200 || oMemReq !== 1'b1) begin
      nErr++;
      $display("FAIL flush_wins: valid=%b addr=%h req=%b, need 0 00000200 1", oValid, oMemAddr, oMemReq);
    end
    exp_q.push_back(ent(32'h200));
    drain(4);
  endtask

  task automatic test_flush_hold();
    restart(1'b1, 0);
    exp_q.push_back(ent(32'h0));
    step();
    iStall = 1'b1;
    step();
    nVec++;
    if (oMemReq !== 1'b0) begin
      nErr++;
      $display("FAIL enter_hold: req=%b, need 0", oMemReq);
    end
    iFlush = 1'b1; iBrTarget = 32'h40;
    step();
    iFlush = 1'b0; iStall = 1'b0;
    nVec++;
    if (oMemAddr !== 32'h40 || oMemReq !== 1'b1 || oValid !== 1'b0) begin
      nErr++;
      $display("FAIL hold_flush: addr=%h req=%b valid=%b, need 00000040 1 0", oMemAddr, oMemReq, oValid);
    end
    exp_q.push_back(ent(32'h40));
    drain(4);
  endtask

  task automatic test_wrap();
    monEn = 1'b0; ack2 = 1'b1;
    step();
    nVec++;
    if (oMemReq2 !== 1'b0 || oPc2 !== 32'h0 || oValid2 !== 1'b0) begin
      nErr++;
      $display("FAIL wrap_reset: req=%b pc=%h valid=%b, need 0 0 0", oMemReq2, oPc2, oValid2);
    end
    nRst2 = 1'b1;
    step();
    nVec++;
    if (oMemReq2 !== 1'b1 || oMemAddr2 !== 32'hFFFF_FFFC) begin
      nErr++;
      $display("FAIL wrap_first_req: req=%b addr=%h, need 1 fffffffc", oMemReq2, oMemAddr2);
    end
    step();
    nVec++;
    if (oPc2 !== 32'hFFFF_FFFC || oValid2 !== 1'b1 || oInstr2 !== memFn(32'hFFFF_FFFC)) begin
      nErr++;
      $display("FAIL wrap_pc0: pc=%h valid=%b instr=%h, need fffffffc 1 %h",
               oPc2, oValid2, oInstr2, memFn(32'hFFFF_FFFC));
    end
    step();
    nVec++;
    if (oPc2 !== 32'h0 || oValid2 !== 1'b1 || oInstr2 !== memFn(32'h0)) begin
      nErr++;
      $display("FAIL wrap_pc1: pc=%h valid=%b instr=%h, need 0 1 %h", oPc2, oValid2, oInstr2, memFn(32'h0));
    end
    ack2 = 1'b0;
    step();
    nVec++;
    if (oStall2 !== 1'b1 || oMemAddr2 !== 32'h4) begin
      nErr++;
      $display("FAIL wrap_wait: stall=%b addr=%h, need 1 00000004", oStall2, oMemAddr2);
    end
    nRst2 = 1'b0; #1;
    nVec++;
    if (oMemAddr2 !== 32'hFFFF_FFFC || oMemReq2 !== 1'b0 || oStall2 !== 1'b0 || oValid2 !== 1'b0) begin
      nErr++;
      $display("FAIL mid_wait_reset: addr=%h req=%b stall=%b valid=%b, need fffffffc 0 0 0",
               oMemAddr2, oMemReq2, oStall2, oValid2);
    end
    nRst2 = 1'b1;
    step();
    nVec++;
    if (oMemReq2 !== 1'b1 || oMemAddr2 !== 32'hFFFF_FFFC) begin
      nErr++;
      $display("FAIL post_reset_req: req=%b addr=%h, need 1 fffffffc", oMemReq2, oMemAddr2);
    end
  endtask

  initial begin
    nRst = 1'b0; nRst2 = 1'b0; ack2 = 1'b0;
    iStall = 1'b0; iFlush = 1'b0; iBrTarget = 32'h0;
    tieAck = 1'b1; ackEn = 1'b0; latency = 0; monEn = 1'b0;
    test_reset();
    test_pipeline();
    test_latency();
    test_stall();
    test_flush();
    test_flush_stall_ack();
    test_flush_hold();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
